// File: rtl/or10_divider_request_adapter.sv
// or10_divider_request_adapter
//
// Sits between the OR10 execute stage and or10_external_divider. It accepts one
// l.div/l.divu request, widens both operands to 40 bits, and offers them on two
// independent AXI-Stream channels. It then waits for the 80-bit divider result
// and returns a 32-bit quotient/remainder with status flags and a one-cycle done
// pulse. Divide-by-zero is answered locally without touching the divider.
//
// Optional build macro: OR10_DIV_TIMEOUT_EN
//   When defined, WAIT is abandoned after TIMEOUT_CYCLES cycles with timed_out_o=1.
//   When undefined, WAIT lasts until the divider answers and timed_out_o is 0.
//
// Ports:
//   clock_i, reset_i              clock shared with the divider; synchronous active-high reset
//   start_i, is_signed_i          request strobe (IDLE only) and l.div/l.divu select
//   dividend_i, divisor_i         32-bit operands
//   busy_o, done_o                busy outside IDLE; one-cycle completion pulse
//   quotient_o, remainder_o       results, held until the next start
//   div_by_zero_o, overflow_o     result flags
//   protocol_error_o              sticky; dout_tvalid seen outside WAIT
//   timed_out_o                   result flag (timeout build only)
//   m_axis_dividend_*             widened dividend channel to the divider
//   m_axis_divisor_*              widened divisor channel to the divider
//   s_axis_dout_*                 80-bit result from the divider, no backpressure

module or10_divider_request_adapter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        is_signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        div_by_zero_o,
  output logic        overflow_o,
  output logic        protocol_error_o,
  output logic        timed_out_o,
  output logic        m_axis_dividend_tvalid_o,
  input  logic        m_axis_dividend_tready_i,
  output logic [39:0] m_axis_dividend_tdata_o,
  output logic        m_axis_divisor_tvalid_o,
  input  logic        m_axis_divisor_tready_i,
  output logic [39:0] m_axis_divisor_tdata_o,
  input  logic        s_axis_dout_tvalid_i,
  input  logic [79:0] s_axis_dout_tdata_i
);

  typedef enum logic [1:0] {StIdle, StSend, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [39:0] dvd_q, dvd_d;
  logic [39:0] dvs_q, dvs_d;
  logic        dvd_sent_q, dvd_sent_d;
  logic        dvs_sent_q, dvs_sent_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic        dbz_q, dbz_d;
  logic        ovf_q, ovf_d;
  logic        perr_q, perr_d;
  logic        dvd_hs, dvs_hs;

`ifdef OR10_DIV_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tout_q, tout_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Upper byte of each 40-bit result field carries only sign/zero extension.
  logic unused_dout;
  assign unused_dout = ^{s_axis_dout_tdata_i[79:72], s_axis_dout_tdata_i[39:32]};

  // tvalid is a pure function of state, so it never depends on tready.
  assign m_axis_dividend_tvalid_o = (state_q == StSend) && !dvd_sent_q;
  assign m_axis_divisor_tvalid_o  = (state_q == StSend) && !dvs_sent_q;
  assign m_axis_dividend_tdata_o  = dvd_q;
  assign m_axis_divisor_tdata_o   = dvs_q;
  assign dvd_hs = m_axis_dividend_tvalid_o && m_axis_dividend_tready_i;
  assign dvs_hs = m_axis_divisor_tvalid_o && m_axis_divisor_tready_i;

  assign busy_o           = (state_q != StIdle);
  assign done_o           = (state_q == StDone);
  assign quotient_o       = quo_q;
  assign remainder_o      = rem_q;
  assign div_by_zero_o    = dbz_q;
  assign overflow_o       = ovf_q;
  assign protocol_error_o = perr_q;

  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    dvd_sent_d = dvd_sent_q;
    dvs_sent_d = dvs_sent_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;
    perr_d     = perr_q;
`ifdef OR10_DIV_TIMEOUT_EN
    tout_d     = tout_q;
    cnt_d      = (state_q == StWait) ? cnt_q + CntW'(1) : '0;
`endif

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          dvd_d      = is_signed_i ? {{8{dividend_i[31]}}, dividend_i} : {8'h00, dividend_i};
          dvs_d      = is_signed_i ? {{8{divisor_i[31]}}, divisor_i} : {8'h00, divisor_i};
          dvd_sent_d = 1'b0;
          dvs_sent_d = 1'b0;
          quo_d      = '0;
          rem_d      = '0;
          dbz_d      = 1'b0;
          ovf_d      = 1'b0;
`ifdef OR10_DIV_TIMEOUT_EN
          tout_d     = 1'b0;
`endif
          if (divisor_i == '0) begin
            rem_d   = dividend_i;
            dbz_d   = 1'b1;
            state_d = StDone;
          end else begin
            ovf_d   = is_signed_i && (dividend_i == 32'h8000_0000)
                      && (divisor_i == 32'hFFFF_FFFF);
            state_d = StSend;
          end
        end
      end
      StSend: begin
        if (dvd_hs) dvd_sent_d = 1'b1;
        if (dvs_hs) dvs_sent_d = 1'b1;
        if (dvd_sent_d && dvs_sent_d) state_d = StWait;
      end
      StWait: begin
        if (s_axis_dout_tvalid_i) begin
          quo_d   = s_axis_dout_tdata_i[71:40];
          rem_d   = s_axis_dout_tdata_i[31:0];
          state_d = StDone;
        end
`ifdef OR10_DIV_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          quo_d   = '0;
          rem_d   = '0;
          tout_d  = 1'b1;
          state_d = StDone;
        end
`endif
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (s_axis_dout_tvalid_i && (state_q != StWait)) perr_d = 1'b1;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      dvd_q      <= '0;
      dvs_q      <= '0;
      dvd_sent_q <= 1'b0;
      dvs_sent_q <= 1'b0;
      quo_q      <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      dvd_sent_q <= dvd_sent_d;
      dvs_sent_q <= dvs_sent_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
      perr_q     <= perr_d;
    end
  end

`ifdef OR10_DIV_TIMEOUT_EN
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      tout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tout_q <= tout_d;
    end
  end
  assign timed_out_o = tout_q;
`else
  assign timed_out_o = 1'b0;
`endif

endmodule

// File: tb/tb_or10_divider_request_adapter.sv
// Bench for or10_divider_request_adapter. A small divider model answers each request
// one cycle after both handshakes; a spec-level model predicts every result.
module tb_or10_divider_request_adapter;

  logic        clk = 1'b0;
  logic        reset_i, start_i, is_signed_i;
  logic [31:0] dividend_i, divisor_i;
  logic        busy_o, done_o, div_by_zero_o, overflow_o, protocol_error_o, timed_out_o;
  logic [31:0] quotient_o, remainder_o;
  logic        dvd_tvalid, dvd_tready, dvs_tvalid, dvs_tready;
  logic [39:0] dvd_tdata, dvs_tdata;
  logic        dout_tvalid = 1'b0;
  logic [79:0] dout_tdata = '0;

  always #5 clk = ~clk;

  or10_divider_request_adapter #(.TIMEOUT_CYCLES(4)) dut (
    .clock_i                  (clk),
    .reset_i                  (reset_i),
    .start_i                  (start_i),
    .is_signed_i              (is_signed_i),
    .dividend_i               (dividend_i),
    .divisor_i                (divisor_i),
    .busy_o                   (busy_o),
    .done_o                   (done_o),
    .quotient_o               (quotient_o),
    .remainder_o              (remainder_o),
    .div_by_zero_o            (div_by_zero_o),
    .overflow_o               (overflow_o),
    .protocol_error_o         (protocol_error_o),
    .timed_out_o              (timed_out_o),
    .m_axis_dividend_tvalid_o (dvd_tvalid),
    .m_axis_dividend_tready_i (dvd_tready),
    .m_axis_dividend_tdata_o  (dvd_tdata),
    .m_axis_divisor_tvalid_o  (dvs_tvalid),
    .m_axis_divisor_tready_i  (dvs_tready),
    .m_axis_divisor_tdata_o   (dvs_tdata),
    .s_axis_dout_tvalid_i     (dout_tvalid),
    .s_axis_dout_tdata_i      (dout_tdata)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Spec-level expectations for the outstanding request.
  logic [31:0] exp_q, exp_r;
  logic        exp_dz, exp_ov, exp_to;
  logic [39:0] exp_wa, exp_wb;
  bit          outstanding = 1'b0;
  bit          expect_hs = 1'b0;
  int          done_seen = 0, done_cyc = 0, done_base = 0, tv_seen = 0, sc = 0;
  int          hs_a = 0, hs_b = 0, base_a = 0, base_b = 0;

  // Divider model state.
  bit          auto_resp = 1'b1;
  logic        got_a = 1'b0, got_b = 1'b0;
  logic [39:0] cap_a = '0, cap_b = '0;
  logic [79:0] resp_data = '0;
  int          resp_req = 0, resp_ack = 0, stray_req = 0, stray_ack = 0;
  logic        hs_now_a, hs_now_b;

  assign hs_now_a = dvd_tvalid && dvd_tready;
  assign hs_now_b = dvs_tvalid && dvs_tready;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model(input logic sg, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dz, output logic ov);
    int sa, sb;
    sa = a;
    sb = b;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      q = 0; r = a; dz = 1'b1;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 0; ov = 1'b1;
    end else if (sg) begin
      q = 32'(sa / sb); r = 32'(sa % sb);
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  function automatic logic [79:0] div40(input logic [39:0] a, input logic [39:0] b);
    logic signed [39:0] x, y, q, r;
    x = a; y = b;
    q = x / y; r = x % y;
    return {q, r};
  endfunction

  // Divider model: capture handshakes, answer once both operands have arrived.
  always @(posedge clk) begin
    if (reset_i) begin
      got_a <= 1'b0;
      got_b <= 1'b0;
    end else begin
      if (hs_now_a) begin hs_a <= hs_a + 1; cap_a <= dvd_tdata; end
      if (hs_now_b) begin hs_b <= hs_b + 1; cap_b <= dvs_tdata; end
      if ((got_a || hs_now_a) && (got_b || hs_now_b)) begin
        got_a <= 1'b0;
        got_b <= 1'b0;
        if (auto_resp) begin
          resp_data <= div40(hs_now_a ? dvd_tdata : cap_a, hs_now_b ? dvs_tdata : cap_b);
          resp_req  <= resp_req + 1;
        end
      end else begin
        if (hs_now_a) got_a <= 1'b1;
        if (hs_now_b) got_b <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    dout_tvalid = 1'b0;
    if (stray_req != stray_ack) begin
      stray_ack++;
      dout_tvalid = 1'b1;
      dout_tdata  = {5{16'hA5C3}};
    end else if (resp_req != resp_ack) begin
      resp_ack++;
      dout_tvalid = 1'b1;
      dout_tdata  = resp_data;
    end
  end

  // Compare process: every non-reset cycle.
  always @(negedge clk) begin
    if (!reset_i) begin
      chk("busy", busy_o, outstanding);
      if (dvd_tvalid) begin tv_seen++; chk("dividend_tdata", dvd_tdata, exp_wa); end
      if (dvs_tvalid) begin tv_seen++; chk("divisor_tdata", dvs_tdata, exp_wb); end
      if (done_o) begin
        chk("done_expected", outstanding, 1);
        chk("quotient", quotient_o, exp_q);
        chk("remainder", remainder_o, exp_r);
        chk("div_by_zero", div_by_zero_o, exp_dz);
        chk("overflow", overflow_o, exp_ov);
        chk("timed_out", timed_out_o, exp_to);
        if (expect_hs) begin
          chk("dividend_handshakes", hs_a - base_a, 1);
          chk("divisor_handshakes", hs_b - base_b, 1);
        end else begin
          chk("no_tvalid", tv_seen, 0);
        end
        outstanding = 1'b0;
        done_cyc = cyc;
        done_seen++;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b);
    step();
    start_i = 1'b1; is_signed_i = sg; dividend_i = a; divisor_i = b;
    model(sg, a, b, exp_q, exp_r, exp_dz, exp_ov);
    exp_to = 1'b0;
    exp_wa = sg ? {{8{a[31]}}, a} : {8'h00, a};
    exp_wb = sg ? {{8{b[31]}}, b} : {8'h00, b};
    expect_hs = (b != 0);
    tv_seen = 0; base_a = hs_a; base_b = hs_b; done_base = done_seen;
    outstanding = 1'b1;
    sc = cyc;
    step();
    // Scramble operands to prove they were latched.
    start_i = 1'b0; dividend_i = ~a; divisor_i = b + 32'd3; is_signed_i = ~sg;
  endtask

  task automatic wait_done(output int lat);
    int n = 0;
    while (done_seen == done_base && n < 20) begin step(); n++; end
    chk("done_arrived", (done_seen != done_base), 1);
    lat = done_cyc - sc;
  endtask

  typedef struct { logic sg; logic [31:0] a; logic [31:0] b; } vec_t;
  vec_t vecs[4] = '{'{1'b0, 32'hFFFF_FFFF, 32'd3}, '{1'b1, 32'd7, 32'hFFFF_FFFE},
                    '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE}, '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF}};

  initial begin
    int lat;
    reset_i = 1'b1; start_i = 1'b0; is_signed_i = 1'b0; dividend_i = '0; divisor_i = '0;
    dvd_tready = 1'b1; dvs_tready = 1'b1;
    repeat (3) step();
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_results", {quotient_o, remainder_o}, 0);
    chk("rst_flags", {div_by_zero_o, overflow_o, protocol_error_o, timed_out_o}, 0);
    chk("rst_tvalids", {dvd_tvalid, dvs_tvalid}, 0);
    chk("rst_tdata", {dvd_tdata, dvs_tdata}, 0);
    reset_i = 1'b0;
    step();

    // Unsigned 100/7.
    issue(1'b0, 32'd100, 32'd7);
    chk("u_tvalids_n1", {dvd_tvalid, dvs_tvalid}, 2'b11);
    chk("u_dvd_tdata", dvd_tdata, 40'h00_0000_0064);
    chk("u_dvs_tdata", dvs_tdata, 40'h00_0000_0007);
    wait_done(lat);
    chk("u_latency", lat, 3);
    chk("u_quotient_lit", quotient_o, 32'd14);
    chk("u_remainder_lit", remainder_o, 32'd2);

    // Signed -100/7.
    issue(1'b1, 32'hFFFF_FF9C, 32'd7);
    chk("s_dvd_tdata", dvd_tdata, 40'hFF_FFFF_FF9C);
    chk("s_dvs_tdata", dvs_tdata, 40'h00_0000_0007);
    wait_done(lat);
    chk("s_latency", lat, 3);
    chk("s_quotient_lit", quotient_o, 32'hFFFF_FFF2);
    chk("s_remainder_lit", remainder_o, 32'hFFFF_FFFE);

    // Divide by zero 5/0.
    issue(1'b0, 32'd5, 32'd0);
    wait_done(lat);
    chk("dz_latency", lat, 1);
    chk("dz_flag_lit", div_by_zero_o, 1);
    chk("dz_remainder_lit", remainder_o, 32'd5);
    step();
    chk("dz_done_pulse", done_o, 0);
    chk("dz_held", {div_by_zero_o, quotient_o, remainder_o}, {1'b1, 32'd0, 32'd5});

    foreach (vecs[i]) begin
      issue(vecs[i].sg, vecs[i].a, vecs[i].b);
      wait_done(lat);
      chk("tbl_latency", lat, 3);
    end

    // Skewed readies: divisor accepted only in N+4.
    dvs_tready = 1'b0;
    issue(1'b0, 32'd1000, 32'd33);
    chk("sk_tvalids_n1", {dvd_tvalid, dvs_tvalid}, 2'b11);
    step();
    chk("sk_tvalids_n2", {dvd_tvalid, dvs_tvalid}, 2'b01);
    step();
    chk("sk_tvalids_n3", {dvd_tvalid, dvs_tvalid}, 2'b01);
    step();
    chk("sk_tvalids_n4", {dvd_tvalid, dvs_tvalid}, 2'b01);
    dvs_tready = 1'b1;
    step();
    chk("sk_wait_n5", {busy_o, dvd_tvalid, dvs_tvalid}, 3'b100);
    wait_done(lat);
    chk("sk_latency", lat, 6);
    chk("sk_quotient_lit", quotient_o, 32'd30);

`ifdef OR10_DIV_TIMEOUT_EN
    auto_resp = 1'b0;
    issue(1'b0, 32'd9, 32'd3);
    exp_q = '0; exp_r = '0; exp_to = 1'b1;
    wait_done(lat);
    chk("to_latency", lat, 6);
    chk("to_flag_lit", timed_out_o, 1);
    chk("to_perr_before", protocol_error_o, 0);
    stray_req++;
    step();
    step();
    chk("to_perr_after", protocol_error_o, 1);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    auto_resp = 1'b1;
    step();
`endif

    // Signed overflow.
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat);
    chk("ov_flag_lit", overflow_o, 1);
    chk("ov_quotient_lit", quotient_o, 32'h8000_0000);

    // Same request, reset while in WAIT.
    auto_resp = 1'b0;
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    step();
    chk("rw_in_wait", {busy_o, dvd_tvalid, dvs_tvalid}, 3'b100);
    reset_i = 1'b1;
    step();
    chk("rw_busy", busy_o, 0);
    chk("rw_tvalids", {dvd_tvalid, dvs_tvalid}, 0);
    chk("rw_flags", {done_o, overflow_o, quotient_o}, 0);
    reset_i = 1'b0;
    outstanding = 1'b0;
    auto_resp = 1'b1;
    step();
    chk("pe_before", protocol_error_o, 0);
    stray_req++;
    step();
    step();
    chk("pe_after", protocol_error_o, 1);
    chk("pe_data_ignored", quotient_o, 0);
    step();
    chk("pe_sticky", protocol_error_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
